pixel_write_buffer: RTL

Write-combining buffer between the voxel GPU's pixel master port and the frame-buffer memory interconnect. It accepts 16-bit pixel writes on an Avalon-MM slave, merges the two halves of a 32-bit word when both arrive, queues completed or aged words in a FIFO, and issues them on a 32-bit Avalon-MM master with byte enables. It decouples GPU `WRITE_OUT` latency from SDRAM/bridge backpressure.

---
 rtl/pixel_write_buffer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_write_buffer.sv
// Write-combining buffer: merges 16-bit pixel writes into 32-bit words, queues them
// in a FIFO and drains them on a 32-bit Avalon-MM master with byte enables.
module pixel_write_buffer #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned FLUSH_TIMEOUT = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              s1_address,
  input  logic [15:0]              s1_writedata,
  input  logic                     s1_write,
  output logic                     s1_waitrequest,
  output logic [31:0]              m1_address,
  output logic [31:0]              m1_writedata,
  output logic [3:0]               m1_byteenable,
  output logic                     m1_write,
  input  logic                     m1_waitrequest,
  input  logic                     flush,
  output logic                     idle,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(FLUSH_TIMEOUT + 1);

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  // pending (combining) register
  logic          r_pend_valid;
  logic [29:0]   r_pend_addr;
  logic [31:0]   r_pend_data;
  logic [3:0]    r_pend_be;
  logic [TW-1:0] r_pend_timer;

  logic          w_pend_valid_n;
  logic [29:0]   w_pend_addr_n;
  logic [31:0]   w_pend_data_n;
  logic [3:0]    w_pend_be_n;
  logic [TW-1:0] w_pend_timer_n;

  // FIFO
  entry_t        r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  entry_t        w_push_entry;
  logic          w_pop;
  entry_t        w_head;

  // output register
  logic          r_m1_write;
  logic [29:0]   r_m1_addr;
  logic [31:0]   r_m1_data;
  logic [3:0]    r_m1_be;

  // incoming write decode
  logic          w_accept;
  logic          w_lane;
  logic [3:0]    w_in_be;
  logic [31:0]   w_in_data;
  logic [31:0]   w_lane_mask;
  logic          w_same_word;
  logic          w_timeout;
  logic          w_unused_addr0;

  assign w_unused_addr0 = s1_address[0];

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == (AW + 1)'(DEPTH));
  assign w_empty = (w_count == '0);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign s1_waitrequest = r_pend_valid && w_full;
  assign w_accept       = s1_write && !s1_waitrequest;

  assign w_lane      = s1_address[1];
  assign w_in_be     = w_lane ? 4'b1100 : 4'b0011;
  assign w_in_data   = w_lane ? {s1_writedata, 16'h0000} : {16'h0000, s1_writedata};
  assign w_lane_mask = w_lane ? 32'hFFFF_0000 : 32'h0000_FFFF;
  assign w_same_word = (s1_address[31:2] == r_pend_addr);
  assign w_timeout   = (r_pend_timer == TW'(FLUSH_TIMEOUT));

  // Pending-register next state and the single FIFO push per cycle.
  // An accepted write always wins over timeout/flush; s1_waitrequest guarantees
  // the FIFO has room for any push an accept causes.
  always_comb begin
    w_pend_valid_n = r_pend_valid;
    w_pend_addr_n  = r_pend_addr;
    w_pend_data_n  = r_pend_data;
    w_pend_be_n    = r_pend_be;
    w_pend_timer_n = r_pend_timer;
    w_push         = 1'b0;
    w_push_entry   = '0;

    if (w_accept) begin
      if (!r_pend_valid) begin
        w_pend_valid_n = 1'b1;
        w_pend_addr_n  = s1_address[31:2];
        w_pend_data_n  = w_in_data;
        w_pend_be_n    = w_in_be;
        w_pend_timer_n = '0;
      end else if (w_same_word && ((r_pend_be & w_in_be) == 4'b0000)) begin
        w_push         = 1'b1;
        w_push_entry   = '{addr: r_pend_addr, data: r_pend_data | w_in_data, be: 4'b1111};
        w_pend_valid_n = 1'b0;
        w_pend_timer_n = '0;
      end else if (w_same_word) begin
        w_pend_data_n  = (r_pend_data & ~w_lane_mask) | w_in_data;
        w_pend_timer_n = '0;
      end else begin
        w_push         = 1'b1;
        w_push_entry   = '{addr: r_pend_addr, data: r_pend_data, be: r_pend_be};
        w_pend_addr_n  = s1_address[31:2];
        w_pend_data_n  = w_in_data;
        w_pend_be_n    = w_in_be;
        w_pend_timer_n = '0;
      end
    end else if (r_pend_valid) begin
      if ((w_timeout || flush) && !w_full) begin
        w_push         = 1'b1;
        w_push_entry   = '{addr: r_pend_addr, data: r_pend_data, be: r_pend_be};
        w_pend_valid_n = 1'b0;
        w_pend_timer_n = '0;
      end else if (!w_timeout) begin
        w_pend_timer_n = r_pend_timer + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_pend_be    <= '0;
      r_pend_timer <= '0;
    end else begin
      r_pend_valid <= w_pend_valid_n;
      r_pend_addr  <= w_pend_addr_n;
      r_pend_data  <= w_pend_data_n;
      r_pend_be    <= w_pend_be_n;
      r_pend_timer <= w_pend_timer_n;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_push_entry;
    end
  end

  assign w_pop = !w_empty && (!r_m1_write || !m1_waitrequest);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_m1_write <= 1'b0;
      r_m1_addr  <= '0;
      r_m1_data  <= '0;
      r_m1_be    <= '0;
    end else if (w_pop) begin
      r_m1_write <= 1'b1;
      r_m1_addr  <= w_head.addr;
      r_m1_data  <= w_head.data;
      r_m1_be    <= w_head.be;
    end else if (r_m1_write && !m1_waitrequest) begin
      r_m1_write <= 1'b0;
    end
  end

  assign m1_write      = r_m1_write;
  assign m1_address    = {r_m1_addr, 2'b00};
  assign m1_writedata  = r_m1_data;
  assign m1_byteenable = r_m1_be;

  assign idle  = !r_pend_valid && w_empty && !r_m1_write;
  assign level = w_count;

endmodule
